// File: rtl/fir_pkg.sv
// Shared definitions for the fir_filter datapath and its output stage.
package fir_pkg;

    localparam int DATA_W = 16;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO. A push onto a full FIFO is accepted only when a pop
// happens in the same cycle.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];

    // Storage has no reset; the head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Output stage behind fir_filter: keeps every Nth sample, applies a saturating
// power-of-two gain and buffers the result in a small FIFO for the sink.
module fir_out_decimator #(
    parameter int DATA_W     = fir_pkg::DATA_W,
    parameter int DEC_W      = 4,
    parameter int SHIFT_W    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic [DEC_W-1:0]              dec_factor,
    input  logic [SHIFT_W-1:0]            gain_shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    import fir_pkg::*;

    // Wide enough that a shift of up to 2^SHIFT_W-1 never loses bits.
    localparam int PW = DATA_W + (1 << SHIFT_W) - 1;

    localparam logic signed [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DEC_W-1:0]         phase;
    logic [DEC_W-1:0]         dec_eff;
    logic                     keep;

    logic signed [PW-1:0]     wide;
    logic signed [PW-1:0]     prod;
    logic [PW-DATA_W:0]       hi_bits;
    logic                     pos_ovf;
    logic                     neg_ovf;
    logic signed [DATA_W-1:0] sat_data;

    logic                     stage_valid;
    logic signed [DATA_W-1:0] stage_data;

    logic [DATA_W-1:0]        head_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     drop;

    assign dec_eff = (dec_factor == '0) ? DEC_W'(1) : dec_factor;
    assign keep    = in_valid && (phase == '0);

    // >= rather than == so that lowering the factor at runtime wraps immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase >= dec_eff - DEC_W'(1)) ? '0 : phase + DEC_W'(1);
        end
    end

    always_comb begin
        wide     = {{(PW-DATA_W){in_data[DATA_W-1]}}, in_data};
        prod     = wide <<< gain_shift;
        hi_bits  = prod[PW-1:DATA_W-1];
        pos_ovf  = !prod[PW-1] && (|hi_bits);
        neg_ovf  = prod[PW-1] && !(&hi_bits);
        sat_data = prod[DATA_W-1:0];
        if (pos_ovf) begin
            sat_data = SAT_HI;
        end else if (neg_ovf) begin
            sat_data = SAT_LO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= keep;
            if (keep) begin
                stage_data <= sat_data;
            end
        end
    end

    // Sink handshake: a word transfers on every rising edge where out_valid and
    // out_ready are both high; out_valid never waits on out_ready, and out_data
    // holds the FIFO head until that transfer.
    fir_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stage_valid),
        .push_data (stage_data),
        .pop       (out_ready),
        .head_data (head_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : $signed(head_data);

    // A full FIFO is never empty, so out_ready alone tells whether a pop frees a slot.
    assign drop = stage_valid && fifo_full && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator with a queue-based scoreboard on the output stream.
module tb_fir_out_decimator;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        dec_factor;
    logic [2:0]        gain_shift;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        fifo_level;
    logic              overflow;
    logic              clr_overflow;

    logic [DATA_W-1:0] exp_q[$];
    int                n_cmp;
    int                n_err;

    fir_out_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .dec_factor   (dec_factor),
        .gain_shift   (gain_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted output word is checked against the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra: got %h, expected nothing", out_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL stream_data: got %h, expected %h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: one valid sample, returning #1 after the edge that samples it.
    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while ((out_valid || exp_q.size() != 0) && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_out_valid", {31'd0, out_valid}, 0);
    endtask

    logic [DATA_W-1:0] sat_in  [6];
    logic [DATA_W-1:0] sat_exp [6];
    logic [2:0]        sat_sh  [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        dec_factor = 4'd1;
        gain_shift = 3'd0;
        out_ready = 1'b1;
        clr_overflow = 1'b0;

        sat_in  = '{16'h4000, 16'hC000, 16'h1000, 16'hFFFF, 16'h0001, 16'h8000};
        sat_sh  = '{3'd1,     3'd1,     3'd2,     3'd3,     3'd7,     3'd0};
        sat_exp = '{16'h7FFF, 16'h8000, 16'h4000, 16'hFFF8, 16'h0080, 16'h8000};

        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_level", {28'd0, fifo_level}, 0);
        chk("reset_out_data", {16'd0, out_data}, 0);
        chk("reset_overflow", {31'd0, overflow}, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse with 2-cycle latency
        exp_q.push_back(16'h7FFF);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 16'h7FFF : 16'h0000;
            @(posedge clk);
            #1;
            if (i == 0) chk("impulse_not_yet_valid", {31'd0, out_valid}, 0);
            if (i == 1) begin
                chk("impulse_valid_at_2", {31'd0, out_valid}, 1);
                chk("impulse_data_at_2", {16'd0, out_data}, 32'h7FFF);
            end
        end
        in_valid = 1'b0;
        drain();
        chk("impulse_overflow", {31'd0, overflow}, 0);

        // Decimation by 4, consecutive then every-other-cycle input
        dec_factor = 4'd4;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(16'd0);
            exp_q.push_back(16'd4);
            exp_q.push_back(16'd8);
            exp_q.push_back(16'd12);
            for (int i = 0; i < 16; i++) begin
                send(16'(i));
                if (r == 1) idle(1);
            end
            drain();
        end

        // Saturating gain
        dec_factor = 4'd1;
        for (int i = 0; i < 6; i++) exp_q.push_back(sat_exp[i]);
        for (int i = 0; i < 6; i++) begin
            gain_shift = sat_sh[i];
            send(sat_in[i]);
        end
        gain_shift = 3'd0;
        drain();

        // Backpressure and overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
        for (int i = 1; i <= 10; i++) send(16'(i));
        idle(2);
        chk("bp_level_full", {28'd0, fifo_level}, 8);
        chk("bp_overflow_set", {31'd0, overflow}, 1);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        chk("bp_overflow_cleared", {31'd0, overflow}, 0);
        send(16'd11);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        chk("bp_set_beats_clear", {31'd0, overflow}, 1);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        chk("bp_overflow_cleared2", {31'd0, overflow}, 0);
        drain();

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 21; i <= 29; i++) exp_q.push_back(16'(i));
        for (int i = 21; i <= 28; i++) send(16'(i));
        idle(2);
        chk("fpp_level_before", {28'd0, fifo_level}, 8);
        send(16'd29);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("fpp_level_after", {28'd0, fifo_level}, 8);
        chk("fpp_no_overflow", {31'd0, overflow}, 0);
        drain();

        // Asynchronous reset with data buffered and phase mid-count
        out_ready = 1'b0;
        dec_factor = 4'd3;
        for (int i = 0; i < 13; i++) send(16'(16'h40 + i));
        idle(2);
        chk("rst_level_before", {28'd0, fifo_level}, 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_level", {28'd0, fifo_level}, 0);
        chk("rst_out_data", {16'd0, out_data}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(16'h0055);
        send(16'h0055);
        send(16'h0056);
        send(16'h0057);
        drain();
        chk("final_overflow", {31'd0, overflow}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
